param_delay_pipe: RTL and testbench
===================================

Name: param_delay_pipe

Overview:
- Parametrised, synthesisable data delay line: WIDTH-bit data through DEPTH register stages, with a per-stage valid bit.
- Output tap selectable at run time; global stall (en) and synchronous flush.
- Optional simulation-only clock-to-out delay, so the Delay_Modelling benches can check timing-annotated behaviour.
- Generalises the single-stage 8-bit register with async active-low reset used in the delay-modelling labs.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- DEPTH, 4, number of pipeline stages (>=2)
- TAP_W, $clog2(DEPTH), width of tap_sel (derived; do not override)
- CNT_W, $clog2(DEPTH+1), width of fill_cnt (derived; do not override)
- TCO, 0, clock-to-out delay in timescale units (1ns) on q_out/out_valid; simulation only, ignored by synthesis

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- d_in  input  WIDTH  data into stage 0
- in_valid  input  1  d_in qualifier, captured with d_in
- en  input  1  shift enable; 0 = hold all stages
- flush  input  1  synchronous clear of all stages
- tap_sel  input  TAP_W  stage index driven to output (0 = stage 0)
- q_out  output  WIDTH  data of selected stage
- out_valid  output  1  valid bit of selected stage
- fill_cnt  output  CNT_W  number of stages currently holding valid=1

Behaviour:
- Storage: stage[0..DEPTH-1] data regs plus vld[0..DEPTH-1] bits.
- Reset (reset_n=0, asynchronous, independent of clk): all stage data = 0, all vld = 0, fill_cnt = 0. q_out = 0 and out_valid = 0 after TCO. Deassertion takes effect at the next rising edge.
- Per rising edge, priority order flush > en:
  - flush=1: all data and vld cleared to 0, regardless of en.
  - flush=0, en=1: stage[0] <= d_in, vld[0] <= in_valid; for k = 1..DEPTH-1, stage[k] <= stage[k-1], vld[k] <= vld[k-1]. Oldest entry is discarded.
  - flush=0, en=0: all stages hold. d_in and in_valid are ignored.
- Output path:
  - q_out = stage[tap_sel], out_valid = vld[tap_sel]. Combinational mux from registers, delayed by #TCO.
  - Latency with en held high: tap_sel+1 clock edges from capture to output.
- tap_sel >= DEPTH (possible only when DEPTH is not a power of 2): clamp to DEPTH-1.
- tap_sel change: output reflects the new stage in the same cycle. No pipeline disturbance.
- fill_cnt:
  - Registered; updated on the same edge as the stages.
  - Equals the popcount of the vld bits after the update.
  - Range 0..DEPTH, no wrap.
  - On flush it goes to 0.
- Invalid data (in_valid=0) still shifts; it occupies a stage with vld=0.
- Reset mid-stream: all data lost immediately. First valid output appears tap_sel+1 enabled edges after the first valid capture post-reset.
- No X propagation: all regs reset. Unknown tap_sel must not be produced by the block itself.
- TCO implemented as a delayed continuous assign on outputs only. Internal state timing is unaffected. TCO=0 gives zero-delay RTL.

Test Plan:
- Defaults. Reset low 20ns, then en=1, in_valid=1, d_in=1,2,3,... every 10ns clock, tap_sel=3 -> q_out=1 with out_valid=1 on the 4th edge after release. fill_cnt goes 1,2,3,4 then holds 4.
- Stall. After pipe is full (stages 8,7,6,5), en=0 for 3 cycles with d_in changing -> q_out, out_valid and fill_cnt frozen. Resume en=1 -> sequence continues with no lost or duplicated value.
- Flush vs en. flush=1 and en=1 on the same edge -> all vld=0, q_out=0, fill_cnt=0 on that edge. Next captured value reaches tap 3 after 4 edges.
- Tap sweep with pipe holding 8,7,6,5 in stages 0..3. tap_sel=0,1,2,3 within one stalled cycle -> q_out = 8,7,6,5 combinationally.
- Async reset mid-stream. reset_n=0 at a non-edge time (e.g. 3ns after an edge) -> q_out=0, out_valid=0, fill_cnt=0 immediately, without waiting for clk.
- Bubbles and TCO. TCO=2, in_valid pattern 1,0,1,0 -> out_valid toggles accordingly at tap 3 and fill_cnt peaks at 2. Outputs change 2ns after the rising edge, never at the edge.

Source files
------------

// File: rtl/param_delay_pipe.sv
// Parametrised WIDTH x DEPTH delay line with per-stage valid bits, a run-time output tap,
// global stall, synchronous flush and an optional simulation-only clock-to-out delay.
module param_delay_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAP_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH + 1),
    parameter int TCO   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_in,
    input  logic             in_valid,
    input  logic             en,
    input  logic             flush,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] q_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] fill_cnt
);

    localparam int SLOTS = 1 << TAP_W;

    logic [WIDTH-1:0] stage [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [WIDTH-1:0] tap_data [SLOTS];
    logic [SLOTS-1:0] tap_vld;
    logic [WIDTH-1:0] q_sel;
    logic             v_sel;

    // Valid bits and fill count share the flush > en priority with the data stages.
    always_comb begin
        vld_next = vld;
        if (flush) begin
            vld_next = '0;
        end else if (en) begin
            vld_next = {vld[DEPTH-2:0], in_valid};
        end
    end

    always_comb begin
        cnt_next = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_next = cnt_next + CNT_W'(vld_next[k]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage[k] <= '0;
            end
            vld <= '0;
            cnt <= '0;
        end else begin
            vld <= vld_next;
            cnt <= cnt_next;
            if (flush) begin
                for (int k = 0; k < DEPTH; k++) begin
                    stage[k] <= '0;
                end
            end else if (en) begin
                stage[0] <= d_in;
                for (int k = 1; k < DEPTH; k++) begin
                    stage[k] <= stage[k-1];
                end
            end
        end
    end

    // Pad the mux to a power of two; out-of-range taps alias the last stage.
    genvar i;
    for (i = 0; i < SLOTS; i++) begin : g_tap
        localparam int SRC = (i < DEPTH) ? i : DEPTH - 1;
        assign tap_data[i] = stage[SRC];
        assign tap_vld[i]  = vld[SRC];
    end

    assign q_sel    = tap_data[tap_sel];
    assign v_sel    = tap_vld[tap_sel];
    assign fill_cnt = cnt;

    if (TCO == 0) begin : g_no_tco
        assign q_out     = q_sel;
        assign out_valid = v_sel;
    end else begin : g_tco
        assign #(TCO) q_out     = q_sel;
        assign #(TCO) out_valid = v_sel;
    end

endmodule

// File: tb/tb_param_delay_pipe.sv
// Directed bench for param_delay_pipe: a zero-delay instance and a TCO=2 instance share stimulus;
// a stage model plus an expected-value queue at tap 3 check both.
module tb_param_delay_pipe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] d_in;
    logic       in_valid;
    logic       en;
    logic       flush;
    logic [1:0] tap_sel;

    logic [7:0] q0;
    logic       v0;
    logic [2:0] f0;
    logic [7:0] q1;
    logic       v1;
    logic [2:0] f1;

    int n_checks = 0;
    int n_errors = 0;
    int peak     = 0;

    logic [7:0] md [4];
    logic [3:0] mv;
    int         mcnt;
    logic [7:0] exp_q [$];

    param_delay_pipe dut (
        .clk(clk), .reset_n(reset_n), .d_in(d_in), .in_valid(in_valid), .en(en),
        .flush(flush), .tap_sel(tap_sel), .q_out(q0), .out_valid(v0), .fill_cnt(f0)
    );

    param_delay_pipe #(.TCO(2)) dut_tco (
        .clk(clk), .reset_n(reset_n), .d_in(d_in), .in_valid(in_valid), .en(en),
        .flush(flush), .tap_sel(tap_sel), .q_out(q1), .out_valid(v1), .fill_cnt(f1)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) md[k] = '0;
        mv   = '0;
        mcnt = 0;
        exp_q.delete();
    endtask

    // One clock: update model at the edge, check TCO timing, then check outputs at the negedge.
    task automatic cycle();
        logic [7:0] pq;
        logic       pv;
        logic       shift;
        logic [7:0] e;
        @(posedge clk);
        pq    = md[tap_sel];
        pv    = mv[tap_sel];
        shift = reset_n && !flush && en;
        if (!reset_n || flush) begin
            model_clear();
        end else if (en) begin
            for (int k = 3; k > 0; k--) md[k] = md[k-1];
            md[0] = d_in;
            mv    = {mv[2:0], in_valid};
            if (in_valid) exp_q.push_back(d_in);
        end
        mcnt = $countones(mv);
        #1;
        check("tco_q_hold", 32'(q1), 32'(pq));
        check("tco_v_hold", 32'(v1), 32'(pv));
        #2;
        check("tco_q_new", 32'(q1), 32'(md[tap_sel]));
        check("tco_v_new", 32'(v1), 32'(mv[tap_sel]));
        check("tco_fill", 32'(f1), 32'(mcnt));
        @(negedge clk);
        check("q_out", 32'(q0), 32'(md[tap_sel]));
        check("out_valid", 32'(v0), 32'(mv[tap_sel]));
        check("fill_cnt", 32'(f0), 32'(mcnt));
        if (int'(f0) > peak) peak = int'(f0);
        if (shift && tap_sel == 2'd3 && v0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $error("FAIL sb_empty: observed=%0h expected=none", q0);
            end else begin
                e = exp_q.pop_front();
                check("sb_q", 32'(q0), 32'(e));
            end
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        d_in     = '0;
        in_valid = 1'b0;
        en       = 1'b0;
        flush    = 1'b0;
        tap_sel  = 2'd3;
        model_clear();

        #12;
        check("rst_q", 32'(q0), 32'd0);
        check("rst_v", 32'(v0), 32'd0);
        check("rst_fill", 32'(f0), 32'd0);
        check("rst_tco_q", 32'(q1), 32'd0);

        // Fill with 1..8 at tap 3.
        @(negedge clk);
        reset_n  = 1'b1;
        en       = 1'b1;
        in_valid = 1'b1;
        d_in     = 8'd1;
        for (int k = 1; k <= 8; k++) begin
            cycle();
            check("fill_seq", 32'(f0), 32'((k < 4) ? k : 4));
            check("fill_valid", 32'(v0), 32'((k >= 4) ? 1 : 0));
            if (k == 4) check("first_out", 32'(q0), 32'd1);
            d_in = 8'(k + 1);
        end

        // Stall with changing d_in; tap sweep inside the stall.
        en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            d_in     = 8'($urandom_range(8'h40, 8'hff));
            in_valid = 1'($urandom_range(0, 1));
            cycle();
            check("stall_q", 32'(q0), 32'd5);
            check("stall_v", 32'(v0), 32'd1);
            check("stall_fill", 32'(f0), 32'd4);
            if (k == 1) begin
                for (int t = 0; t < 4; t++) begin
                    tap_sel = 2'(t);
                    #1;
                    check("tap_sweep", 32'(q0), 32'(8 - t));
                    check("tap_sweep_v", 32'(v0), 32'd1);
                end
                tap_sel = 2'd3;
            end
        end

        // Resume: 6,7,8,9 must follow without gaps or repeats.
        en       = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            d_in = 8'(9 + k);
            cycle();
            check("resume_q", 32'(q0), 32'(6 + k));
        end

        // Flush wins over en on the same edge.
        flush = 1'b1;
        d_in  = 8'h55;
        cycle();
        check("flush_q", 32'(q0), 32'd0);
        check("flush_v", 32'(v0), 32'd0);
        check("flush_fill", 32'(f0), 32'd0);
        flush = 1'b0;

        // Bubbles 1,0,1,0 then idle; tap 3 must show 1,0,1,0 on edges 4..7.
        peak = 0;
        for (int k = 0; k < 8; k++) begin
            d_in     = 8'(8'h20 + k);
            in_valid = (k < 4) ? ~1'(k & 1) : 1'b0;
            cycle();
            if (k >= 3 && k <= 6) check("bubble_v", 32'(v0), 32'((k == 3 || k == 5) ? 1 : 0));
            if (k == 3) check("bubble_q", 32'(q0), 32'h20);
        end
        check("bubble_peak", 32'(peak), 32'd2);

        // Refill, then asynchronous reset 3ns after an edge.
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            d_in = 8'($urandom_range(1, 255));
            cycle();
        end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_q", 32'(q0), 32'd0);
        check("async_v", 32'(v0), 32'd0);
        check("async_fill", 32'(f0), 32'd0);
        #2;
        check("async_tco_q", 32'(q1), 32'd0);
        check("async_tco_v", 32'(v1), 32'd0);
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            d_in = 8'(8'h70 + k);
            cycle();
            check("post_rst_v", 32'(v0), 32'((k >= 4) ? 1 : 0));
        end
        check("post_rst_q", 32'(q0), 32'h72);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
